cim_readout_seq: RTL and testbench

Sequencer that sits directly upstream and downstream of the CIM system I/O stage. On a `start` command it issues the calibration/compute request (`cal`) and waits for `cal_done`. It then sweeps the 5-bit output address, samples the 6-bit result bus `q` for each output, and streams the results to the host over a valid/ready interface. It owns the `a_chip[4:0]`, `cal` and `eact` drive during a readout; weight and buffer writes stay with the host.

---
 rtl/cim_pkg.sv | 25 ++
 rtl/cim_edge_det.sv | 25 ++
 rtl/cim_readout_seq.sv | 143 ++++++++++++++
 tb/tb_cim_readout_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared definitions for the CIM readout path.
//   rd_state_t       : readout sequencer state encoding
//   CIM_ADDR_W/Q_W   : output-address and result-bus widths
//   CIM_* defaults   : default job geometry and calibration timeout
package cim_pkg;

  localparam int CIM_ADDR_W = 5;
  localparam int CIM_Q_W    = 6;
  localparam int CIM_CNT_W  = 4;   // settle counter, SETTLE up to 15
  localparam int CIM_TMO_W  = 16;  // timeout counter, CAL_TIMEOUT up to 65535

  localparam int CIM_NUM_OUT     = 32;
  localparam int CIM_SETTLE      = 2;
  localparam int CIM_CAL_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAL    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_PUSH   = 3'd4,
    ST_FIN    = 3'd5
  } rd_state_t;

endpackage

// File: rtl/cim_edge_det.sv
// Rising-edge detector with a history register that resets to 1.
// A strobe that is already high when reset releases (or when the consumer
// starts looking) is not reported until it falls and rises again.
//   clk, rst : clock, asynchronous active-high reset
//   i_sig    : strobe to watch (level or pulse)
//   o_rise   : high in the cycle i_sig is 1 and was 0 the cycle before
module cim_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/cim_readout_seq.sv
// Readout sequencer around the CIM system I/O stage.
// On start: pulse cal, wait for a rising cal_done (with timeout), then for
// each output address hold a_out for SETTLE cycles, sample q_in, and offer
// the result on a valid/ready stream. done pulses after the last handshake,
// err pulses if cal_done never rises.
//   clk, rst              : clock, asynchronous active-high reset
//   i_start, i_act_en     : job request and its activation enable
//   o_busy, o_cal         : job in progress, one-cycle calibration request
//   i_cal_done            : calibration/compute completion (level or pulse)
//   o_a_out, o_eact       : output address and activation enable to the array
//   i_q_in                : result bus
//   o_m_valid/i_m_ready   : result stream handshake
//   o_m_data, o_m_idx     : sampled result and the address it came from
//   o_done, o_err         : end-of-job and calibration-timeout pulses
module cim_readout_seq
  import cim_pkg::*;
#(
  parameter int NUM_OUT     = CIM_NUM_OUT,
  parameter int SETTLE      = CIM_SETTLE,
  parameter int CAL_TIMEOUT = CIM_CAL_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_act_en,
  output logic                  o_busy,
  output logic                  o_cal,
  input  logic                  i_cal_done,
  output logic [CIM_ADDR_W-1:0] o_a_out,
  output logic                  o_eact,
  input  logic [CIM_Q_W-1:0]    i_q_in,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [CIM_Q_W-1:0]    o_m_data,
  output logic [CIM_ADDR_W-1:0] o_m_idx,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [CIM_ADDR_W-1:0] LAST_ADDR   = CIM_ADDR_W'(NUM_OUT - 1);
  localparam logic [CIM_CNT_W-1:0]  SETTLE_LOAD = CIM_CNT_W'(SETTLE - 1);
  localparam logic [CIM_TMO_W-1:0]  TMO_LAST    = CIM_TMO_W'(CAL_TIMEOUT - 1);

  rd_state_t             r_state;
  logic                  r_act;
  logic [CIM_ADDR_W-1:0] r_addr;
  logic [CIM_ADDR_W-1:0] r_a_out;
  logic [CIM_CNT_W-1:0]  r_cnt;
  logic [CIM_TMO_W-1:0]  r_tmo;
  logic [CIM_Q_W-1:0]    r_m_data;
  logic [CIM_ADDR_W-1:0] r_m_idx;
  logic                  r_err;
  logic                  w_cal_rise;

  // The detector runs continuously; only WAIT looks at it, so edges in any
  // other state are ignored, and a level still high on WAIT entry has
  // history 1 and is not reported.
  cim_edge_det u_cal_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (i_cal_done),
    .o_rise (w_cal_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_act    <= 1'b0;
      r_addr   <= '0;
      r_a_out  <= '0;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_m_data <= '0;
      r_m_idx  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_act   <= i_act_en;
            r_addr  <= '0;
            r_tmo   <= '0;
            r_state <= ST_CAL;
          end
        end
        ST_CAL: r_state <= ST_WAIT;
        ST_WAIT: begin
          // Comparing against CAL_TIMEOUT-1 before incrementing makes the
          // abort land on the CAL_TIMEOUT-th WAIT cycle.
          if (w_cal_rise) begin
            r_cnt   <= SETTLE_LOAD;
            r_a_out <= r_addr;
            r_state <= ST_SETTLE;
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_m_data <= i_q_in;
            r_m_idx  <= r_addr;
            r_state  <= ST_PUSH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_PUSH: begin
          // Result registers are only written in SETTLE, so they hold while
          // the host stalls.
          if (i_m_ready) begin
            if (r_addr == LAST_ADDR) begin
              r_state <= ST_FIN;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_a_out <= r_addr + 1'b1;
              r_cnt   <= SETTLE_LOAD;
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs are decodes of the state register only; no input reaches
  // an output without passing through a flop.
  assign o_busy    = (r_state != ST_IDLE);
  assign o_cal     = (r_state == ST_CAL);
  assign o_m_valid = (r_state == ST_PUSH);
  assign o_done    = (r_state == ST_FIN);
  assign o_eact    = o_busy & r_act;
  assign o_a_out   = r_a_out;
  assign o_m_data  = r_m_data;
  assign o_m_idx   = r_m_idx;
  assign o_err     = r_err;

endmodule

// File: tb/tb_cim_readout_seq.sv
// Scoreboard bench for cim_readout_seq. Each job pushes the words it should
// produce (index i, data f(i)) into a queue; a negedge monitor pops and
// compares on every handshake and checks hold/eact/done behaviour.
module tb_cim_readout_seq;

  localparam int NUM_OUT     = 32;
  localparam int SETTLE      = 2;
  localparam int CAL_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, act_en = 1'b0, cal_done = 1'b0, m_ready = 1'b1;
  logic [5:0] q_in = '0;
  logic       o_busy, o_cal, o_eact, o_m_valid, o_done, o_err;
  logic [4:0] o_a_out, o_m_idx;
  logic [5:0] o_m_data;

  cim_readout_seq #(.NUM_OUT(NUM_OUT), .SETTLE(SETTLE), .CAL_TIMEOUT(CAL_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_act_en(act_en), .o_busy(o_busy),
    .o_cal(o_cal), .i_cal_done(cal_done), .o_a_out(o_a_out), .o_eact(o_eact),
    .i_q_in(q_in), .o_m_valid(o_m_valid), .i_m_ready(m_ready), .o_m_data(o_m_data),
    .o_m_idx(o_m_idx), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [4:0] idx; logic [5:0] data; } word_t;
  word_t exp_q[$];
  word_t mw;

  int n_vec = 0, n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array model: address a reads seed + mul*a once it has been stable for
  // SETTLE-1 cycles; before that the bus carries the complement (not settled).
  logic [5:0] q_seed = 6'h10, q_mul = 6'h01;
  function automatic logic [5:0] qf(input logic [4:0] a);
    logic [5:0] a6;
    a6 = {1'b0, a};
    return 6'(q_seed + q_mul * a6);
  endfunction

  logic [4:0] prev_a = '0;
  int age = 100;
  always @(posedge clk) begin
    #1;
    if (o_a_out != prev_a) age = 0;
    else if (age < 100) age++;
    prev_a = o_a_out;
    q_in = (age >= SETTLE - 1) ? qf(o_a_out) : ~qf(o_a_out);
  end

  // Host ready: optional random, plus a fixed stall on one chosen word.
  int bp_idx = -1, stall_len = 7, stall_cnt = 0;
  bit bp_fired = 0, rand_ready = 0;
  always @(posedge clk) begin
    #1;
    if (rst) stall_cnt = 0;
    else if (bp_idx >= 0 && !bp_fired && o_m_valid && o_m_idx == bp_idx[4:0]) begin
      bp_fired  = 1;
      stall_cnt = stall_len;
    end
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  bit pv = 0, phs = 0, exp_done_now = 0, job_act = 0, fixed_timing = 0;
  logic [5:0] p_data;
  logic [4:0] p_idx, p_aout;
  int k_cyc = 0, prev_hs = 0, hs_n = 0, done_seen = 0, err_seen = 0, bp_stalls = 0;

  always @(negedge clk) begin
    if (rst) begin
      pv = 0; phs = 0; exp_done_now = 0;
    end else begin
      if (pv && !phs) begin
        check("hold_valid", o_m_valid, 1);
        check("hold_data", o_m_data, p_data);
        check("hold_idx", o_m_idx, p_idx);
        check("hold_a_out", o_a_out, p_aout);
      end
      if (o_busy) check("eact_busy", o_eact, job_act);
      else        check("eact_idle", o_eact, 0);
      if (exp_done_now) begin
        check("done_after_last", o_done, 1);
        exp_done_now = 0;
      end else if (o_done) begin
        check("unexpected_done", o_done, 0);
      end
      done_seen += int'(o_done);
      err_seen  += int'(o_err);
      if (o_m_valid && !m_ready && bp_idx >= 0 && o_m_idx == bp_idx[4:0]) bp_stalls++;
      if (o_m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("word_expected", exp_q.size(), 1);
        end else begin
          mw = exp_q.pop_front();
          check("word_idx", o_m_idx, mw.idx);
          check("word_data", o_m_data, mw.data);
          if (fixed_timing) begin
            if (hs_n == 0) check("first_word_cycle", cyc, k_cyc + SETTLE + 1);
            else           check("word_period", cyc - prev_hs, SETTLE + 1);
          end
          if (mw.idx == 5'(NUM_OUT - 1)) exp_done_now = 1;
        end
        prev_hs = cyc;
        hs_n++;
      end
      pv = o_m_valid; phs = o_m_valid && m_ready;
      p_data = o_m_data; p_idx = o_m_idx; p_aout = o_a_out;
    end
  end

  task automatic load_expect(input logic [5:0] seed, input logic [5:0] mul);
    word_t w;
    q_seed = seed;
    q_mul  = mul;
    hs_n   = 0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w.idx  = 5'(i);
      w.data = qf(5'(i));
      exp_q.push_back(w);
    end
  endtask

  task automatic issue_start(input bit act);
    @(posedge clk); #1;
    start = 1'b1; act_en = act; job_act = act;
    @(posedge clk); #1;
    start = 1'b0; act_en = ~act;
    check("cal_pulse", o_cal, 1);
    check("busy_rise", o_busy, 1);
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (o_done) begin at = cyc; break; end
    end
    if (at < 0) check("done_timeout", o_done, 1);
  endtask

  task automatic run_job(input bit act, input logic [5:0] seed, input logic [5:0] mul,
                         input int dly, input bit fixed, input bit level);
    int at, d0, e0;
    d0 = done_seen; e0 = err_seen;
    fixed_timing = fixed;
    load_expect(seed, mul);
    issue_start(act);
    @(posedge clk); #1;
    check("cal_one_cycle", o_cal, 0);
    for (int i = 1; i < dly; i++) begin @(posedge clk); #1; end
    cal_done = 1'b1;
    k_cyc = cyc;
    if (!level) begin @(posedge clk); #1; cal_done = 1'b0; end
    wait_done(4000, at);
    if (fixed) check("done_latency", at, k_cyc + NUM_OUT * (SETTLE + 1) + 1);
    check("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    check("busy_after_done", o_busy, 0);
    check("eact_after_done", o_eact, 0);
    check("one_done_per_job", done_seen - d0, 1);
    check("no_err_in_job", err_seen - e0, 0);
    cal_done = 1'b0;
    fixed_timing = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_cal"}, o_cal, 0);
    check({tag, "_a_out"}, o_a_out, 0);
    check({tag, "_eact"}, o_eact, 0);
    check({tag, "_m_valid"}, o_m_valid, 0);
    check({tag, "_m_data"}, o_m_data, 0);
    check({tag, "_m_idx"}, o_m_idx, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int at, d0, e0, err_at, seen;

    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic job, q = 0x10 + a, cal_done 5 cycles after cal, ready high
    run_job(1'b0, 6'h10, 6'h01, 5, 1'b1, 1'b1);
    // Full sweep with activation enabled, random data pattern
    run_job(1'b1, 6'($urandom), 6'($urandom_range(0, 31) * 2 + 1), 5, 1'b1, 1'b0);

    // Backpressure on word 1
    bp_idx = 1; bp_fired = 0; stall_len = 7; bp_stalls = 0;
    run_job(1'($urandom), 6'h10, 6'h01, 3, 1'b0, 1'b1);
    check("bp_stall_cycles", bp_stalls, 7);
    bp_idx = -1;

    // Random jobs with random host ready
    rand_ready = 1;
    for (int j = 0; j < 4; j++)
      run_job(1'($urandom), 6'($urandom), 6'($urandom_range(0, 31) * 2 + 1),
              $urandom_range(1, 15), 1'b0, 1'($urandom));
    rand_ready = 0;
    repeat (2) @(posedge clk);

    // Stale cal_done: high before start, must fall and rise again
    d0 = done_seen;
    cal_done = 1'b1;
    repeat (2) @(posedge clk);
    load_expect(6'($urandom), 6'h03);
    issue_start(1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("stale_no_valid", o_m_valid, 0);
      check("stale_busy", o_busy, 1);
      start = (i == 4);
    end
    cal_done = 1'b0;
    @(posedge clk); #1;
    cal_done = 1'b1;
    k_cyc = cyc;
    fixed_timing = 1;
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(4000, at);
    check("stale_done_latency", at, k_cyc + NUM_OUT * (SETTLE + 1) + 1);
    fixed_timing = 0;
    cal_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("start_not_queued", o_busy, 0);
    end
    check("stale_one_done", done_seen - d0, 1);

    // Calibration timeout
    e0 = err_seen;
    issue_start(1'b0);
    err_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (o_err && err_at < 0) err_at = i;
    end
    check("err_latency", err_at, CAL_TIMEOUT + 1);
    check("err_single_pulse", err_seen - e0, 1);
    check("idle_after_err", o_busy, 0);

    // Reset in PUSH on word 2 while the host stalls
    bp_idx = 2; bp_fired = 0; stall_len = 20;
    load_expect(6'h10, 6'h01);
    issue_start(1'b1);
    repeat (3) @(posedge clk);
    #1 cal_done = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (o_m_valid && o_m_idx == 5'd2 && !m_ready) seen = 1;
    end
    check("reached_word2", seen, 1);
    d0 = done_seen; e0 = err_seen;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    bp_idx = -1; stall_len = 7; cal_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", done_seen - d0, 0);
    check("no_err_after_reset", err_seen - e0, 0);
    check("idle_after_reset", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
